neural_pass_sequencer: RTL and testbench
========================================

NEURAL_PASS_SEQUENCER -- requirements
Module: neural_pass_sequencer

Interface
REQ-001 Parameter NUM_WIDTH, default 64: width of bus data words and core data.
REQ-002 Parameter IDX_WIDTH, default 10: width of each of the two index fields.
REQ-003 Parameter REGION_WIDTH, default 4: region field width; addr = {region, idx_hi, idx_lo}.
REQ-004 Parameter FWD_CYCLES, default 6: forward-pass settle cycles (>=1).
REQ-005 Parameter BWD_CYCLES, default 6: backprop settle cycles (>=1).
REQ-006 Parameter CTRL_REGION, default 7: region value decoded as the control region.
REQ-007 clk  in  1: single clock, rising-edge.
REQ-008 rst_n  in  1: reset, asynchronous and active-low.
REQ-009 addr  in  REGION_WIDTH+2*IDX_WIDTH: host address.
REQ-010 data_in  in  NUM_WIDTH: host write data.
REQ-011 we  in  1: host write enable, sampled each clk.
REQ-012 data_out  out  NUM_WIDTH: registered host read data.
REQ-013 core_addr  out  REGION_WIDTH+2*IDX_WIDTH: address to neural core.
REQ-014 core_wdata  out  NUM_WIDTH: write data to core.
REQ-015 core_we  out  1: core write strobe, one cycle per accepted write.
REQ-016 core_rdata  in  NUM_WIDTH: combinational core read data for core_addr.
REQ-017 fp_hold  out  1: high freezes core forward datapath; low lets it propagate.
REQ-018 bp_hold  out  1: high freezes core weight update; low lets it update.
REQ-019 busy  out  1: high whenever FSM not in IDLE.

Function
REQ-020 FSM states IDLE, FWD, BWD; fp_hold=0 only in FWD, bp_hold=0 only in BWD.
REQ-021 Control writes (region==CTRL_REGION, we=1, idx_hi=0), by idx_lo: 0 start forward if data_in[0]; 1 start backprop if data_in[0]; 4 mode register (bit0 = chain: FWD then BWD); 5 clear sticky error if data_in[0].
REQ-022 Start forward in IDLE: next cycle state=FWD, settle counter loaded FWD_CYCLES-1, decrements each cycle.
REQ-023 FWD with counter 0: go BWD (counter BWD_CYCLES-1) if chain=1, else IDLE; FWD lasts exactly FWD_CYCLES cycles.
REQ-024 Start backprop in IDLE: state=BWD for exactly BWD_CYCLES cycles, then IDLE.
REQ-025 Start command while busy=1: ignored, sticky error bit0 set; state unchanged.
REQ-026 Non-control write while busy=0: core_addr/core_wdata driven from addr/data_in, core_we=1 the following cycle (1-cycle latency).
REQ-027 Non-control write while busy=1: not forwarded (core_we stays 0), sticky error bit1 set.
REQ-028 Reads: data_out updates every cycle to value selected by addr on previous edge (1-cycle latency); no read strobe.
REQ-029 Control reads by idx_lo: 2 status {error[1:0], state[1:0], busy} in LSBs, zero-extended; 3 pass counter; 4 mode; others 0.
REQ-030 Non-control reads: core_addr follows addr when core_we=0; data_out = registered core_rdata.
REQ-031 Pass counter: NUM_WIDTH bits, +1 on each return to IDLE, wraps to 0 from all-ones.
REQ-032 Error set and clear in same cycle: set wins.
REQ-033 Start forward and start backprop cannot coincide (one address per cycle); no priority rule needed.

Reset
REQ-034 rst_n=0 asynchronously forces: state IDLE, fp_hold=1, bp_hold=1, busy=0, core_we=0, core_addr=0, core_wdata=0, data_out=0, mode=0, error=0, pass counter=0, settle counter=0.
REQ-035 Reset mid-pass aborts immediately; pass counter not incremented; first post-reset edge behaves as IDLE.

Structure
REQ-036 Shared package holds FSM state encoding, control idx_lo constants (0-5), status bit positions.
REQ-037 One sub-module natural: neural_settle_counter (load, decrement, zero flag), instantiated once.

Verification
REQ-038 Write control idx0=1, chain=0, FWD_CYCLES=6 -> fp_hold low exactly 6 cycles, busy high 6 cycles, pass counter reads 1.
REQ-039 Write mode=1 then start forward -> fp_hold low 6 cycles, then bp_hold low 6 cycles, busy 12 cycles, counter +1 once.
REQ-040 Write region 2 addr idx 7/3 data 15 while idle -> core_we pulse one cycle, core_wdata=15; repeat during pass -> no core_we, status error bit1=1.
REQ-041 Start forward while BWD active -> ignored, error bit0=1; write idx5=1 -> status error reads 0.
REQ-042 Assert rst_n=0 in 3rd FWD cycle -> fp_hold=1, busy=0 same cycle, pass counter stays 0.
REQ-043 Preload pass counter to all-ones via force, run a pass -> counter reads 0.

Source files
------------

// File: rtl/neural_pass_sequencer_pkg.sv
// rtl/neural_pass_sequencer_pkg.sv - shared state encoding, control map and status layout
package neural_pass_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_BWD  = 2'd2
    } state_t;

    localparam int CTRL_START_FWD = 0;
    localparam int CTRL_START_BWD = 1;
    localparam int CTRL_STATUS    = 2;
    localparam int CTRL_PASS_CNT  = 3;
    localparam int CTRL_MODE      = 4;
    localparam int CTRL_CLR_ERR   = 5;

    // status word: {error[1:0], state[1:0], busy}
    localparam int STAT_BUSY      = 0;
    localparam int STAT_STATE_LSB = 1;
    localparam int STAT_ERR_LSB   = 3;
    localparam int STATUS_WIDTH   = 5;

    localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/neural_settle_counter.sv
// rtl/neural_settle_counter.sv - loadable down-counter with zero flag for pass settle timing
module neural_settle_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/neural_pass_sequencer.sv
// rtl/neural_pass_sequencer.sv - host-controlled forward/backprop pass sequencer for a neural core
module neural_pass_sequencer
    import neural_pass_sequencer_pkg::*;
#(
    parameter int NUM_WIDTH    = 64,
    parameter int IDX_WIDTH    = 10,
    parameter int REGION_WIDTH = 4,
    parameter int FWD_CYCLES   = 6,
    parameter int BWD_CYCLES   = 6,
    parameter int CTRL_REGION  = 7
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [REGION_WIDTH+2*IDX_WIDTH-1:0] addr,
    input  logic [NUM_WIDTH-1:0]              data_in,
    input  logic                              we,
    output logic [NUM_WIDTH-1:0]              data_out,
    output logic [REGION_WIDTH+2*IDX_WIDTH-1:0] core_addr,
    output logic [NUM_WIDTH-1:0]              core_wdata,
    output logic                              core_we,
    input  logic [NUM_WIDTH-1:0]              core_rdata,
    output logic                              fp_hold,
    output logic                              bp_hold,
    output logic                              busy
);

    localparam int AW = REGION_WIDTH + 2*IDX_WIDTH;
    localparam logic [CNT_WIDTH-1:0] FWD_LOAD = CNT_WIDTH'(FWD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] BWD_LOAD = CNT_WIDTH'(BWD_CYCLES - 1);

    logic [REGION_WIDTH-1:0] region;
    logic [IDX_WIDTH-1:0]    idx_hi;
    logic [IDX_WIDTH-1:0]    idx_lo;
    logic                    is_ctrl_region;
    logic                    ctrl_sel;
    logic                    ctrl_wr;
    logic                    start_fwd;
    logic                    start_bwd;
    logic                    host_wr;
    logic                    err_clr;
    logic [1:0]              err_set;

    state_t                  state_q;
    state_t                  state_d;
    logic                    cnt_load;
    logic [CNT_WIDTH-1:0]    cnt_load_value;
    logic                    cnt_zero;
    logic                    pass_done;

    logic                    mode_q;
    logic [1:0]              error_q;
    logic [NUM_WIDTH-1:0]    pass_count;
    logic [AW-1:0]           wr_addr_q;
    logic [STATUS_WIDTH-1:0] status_word;
    logic [NUM_WIDTH-1:0]    rd_data;

    assign region = addr[AW-1 -: REGION_WIDTH];
    assign idx_hi = addr[2*IDX_WIDTH-1 -: IDX_WIDTH];
    assign idx_lo = addr[IDX_WIDTH-1:0];

    assign is_ctrl_region = (region == REGION_WIDTH'(CTRL_REGION));
    assign ctrl_sel       = is_ctrl_region && (idx_hi == '0);
    assign ctrl_wr        = we && ctrl_sel;
    assign start_fwd      = ctrl_wr && (idx_lo == IDX_WIDTH'(CTRL_START_FWD)) && data_in[0];
    assign start_bwd      = ctrl_wr && (idx_lo == IDX_WIDTH'(CTRL_START_BWD)) && data_in[0];
    assign err_clr        = ctrl_wr && (idx_lo == IDX_WIDTH'(CTRL_CLR_ERR)) && data_in[0];
    assign host_wr        = we && !is_ctrl_region;
    assign err_set        = {host_wr && busy, (start_fwd || start_bwd) && busy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_fwd) begin
                    state_d        = ST_FWD;
                    cnt_load       = 1'b1;
                    cnt_load_value = FWD_LOAD;
                end else if (start_bwd) begin
                    state_d        = ST_BWD;
                    cnt_load       = 1'b1;
                    cnt_load_value = BWD_LOAD;
                end
            end
            ST_FWD: begin
                if (cnt_zero) begin
                    if (mode_q) begin
                        state_d        = ST_BWD;
                        cnt_load       = 1'b1;
                        cnt_load_value = BWD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BWD: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fp_hold = (state_q != ST_FWD);
        bp_hold = (state_q != ST_BWD);
        busy    = (state_q != ST_IDLE);
    end

    neural_settle_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_settle (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cnt_load),
        .load_value(cnt_load_value),
        .dec       (busy),
        .zero      (cnt_zero)
    );

    assign pass_done = busy && (state_d == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 1'b0;
            error_q    <= 2'b00;
            pass_count <= '0;
        end else begin
            if (ctrl_wr && (idx_lo == IDX_WIDTH'(CTRL_MODE))) begin
                mode_q <= data_in[0];
            end
            // a set arriving with a clear still leaves the bit set
            error_q <= (err_clr ? 2'b00 : error_q) | err_set;
            if (pass_done) begin
                pass_count <= pass_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_we    <= 1'b0;
            wr_addr_q  <= '0;
            core_wdata <= '0;
        end else begin
            core_we <= host_wr && !busy;
            if (host_wr && !busy) begin
                wr_addr_q  <= addr;
                core_wdata <= data_in;
            end
        end
    end

    // Reads need core_rdata for the current addr, so the core sees addr directly
    // except while a forwarded write is being presented.
    assign core_addr = core_we ? wr_addr_q : (rst_n ? addr : '0);

    always_comb begin
        status_word                            = '0;
        status_word[STAT_BUSY]                 = busy;
        status_word[STAT_STATE_LSB +: 2]       = state_q;
        status_word[STAT_ERR_LSB +: 2]         = error_q;
    end

    always_comb begin
        rd_data = '0;
        if (ctrl_sel) begin
            case (idx_lo)
                IDX_WIDTH'(CTRL_STATUS):   rd_data = NUM_WIDTH'(status_word);
                IDX_WIDTH'(CTRL_PASS_CNT): rd_data = pass_count;
                IDX_WIDTH'(CTRL_MODE):     rd_data = NUM_WIDTH'(mode_q);
                default:                   rd_data = '0;
            endcase
        end else if (!is_ctrl_region) begin
            rd_data = core_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else begin
            data_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_neural_pass_sequencer.sv
// tb/tb_neural_pass_sequencer.sv - scoreboard bench for neural_pass_sequencer
module tb_neural_pass_sequencer;

    localparam int K_DATA  = 0;
    localparam int K_HOLD  = 1;
    localparam int K_CADDR = 2;
    localparam logic [63:0] CORE_KEY = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] addr;
    logic [63:0] data_in;
    logic        we;
    logic [63:0] data_out;
    logic [23:0] core_addr;
    logic [63:0] core_wdata;
    logic        core_we;
    logic [63:0] core_rdata;
    logic        fp_hold;
    logic        bp_hold;
    logic        busy;

    always #5 clk = ~clk;

    assign core_rdata = {40'h0, core_addr} ^ CORE_KEY;

    neural_pass_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .data_in   (data_in),
        .we        (we),
        .data_out  (data_out),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_we   (core_we),
        .core_rdata(core_rdata),
        .fp_hold   (fp_hold),
        .bp_hold   (bp_hold),
        .busy      (busy)
    );

    typedef struct {
        int          kind;
        int          due;
        logic [63:0] exp;
        string       name;
    } exp_t;

    typedef struct {
        logic [23:0] a;
        logic [63:0] d;
    } wr_t;

    exp_t eq[$];
    wr_t  wq[$];
    wr_t  w;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [23:0] caddr(input int region, input int hi, input int lo);
        return {region[3:0], hi[9:0], lo[9:0]};
    endfunction

    function automatic void expect_at(input int kind, input int due, input logic [63:0] exp, input string name);
        exp_t e;
        e.kind = kind; e.due = due; e.exp = exp; e.name = name;
        eq.push_back(e);
    endfunction

    // monitor: compares whatever expectations fall due on this cycle, plus every core write
    always @(negedge clk) begin
        for (int i = eq.size() - 1; i >= 0; i--) begin
            if (eq[i].due == cyc) begin
                case (eq[i].kind)
                    K_DATA:  chk(eq[i].name, data_out, eq[i].exp);
                    K_HOLD:  chk(eq[i].name, {61'b0, fp_hold, bp_hold, busy}, eq[i].exp);
                    default: chk(eq[i].name, {40'b0, core_addr}, eq[i].exp);
                endcase
                eq.delete(i);
            end
        end
        if (core_we === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexpected core_we", 64'd1, 64'd0);
            end else begin
                w = wq.pop_front();
                chk("core_addr on write", {40'b0, core_addr}, {40'b0, w.a});
                chk("core_wdata", core_wdata, w.d);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        we = 1'b0; addr = '0; data_in = '0;
        repeat (n) step();
    endtask

    task automatic wr(input logic [23:0] a, input logic [63:0] d);
        we = 1'b1; addr = a; data_in = d;
        step();
        we = 1'b0; addr = '0; data_in = '0;
    endtask

    task automatic rd(input logic [23:0] a, input logic [63:0] exp, input string name);
        we = 1'b0; addr = a;
        expect_at(K_DATA, cyc + 1, exp, name);
        step();
        addr = '0;
    endtask

    // {fp_hold, bp_hold, busy}: 011 in FWD, 101 in BWD, 110 in IDLE
    task automatic hold_profile(input int first, input int nf, input int nb, input string name);
        expect_at(K_HOLD, first - 1, 64'b110, {name, " pre"});
        for (int i = 0; i < nf; i++) expect_at(K_HOLD, first + i, 64'b011, {name, " fwd"});
        for (int i = 0; i < nb; i++) expect_at(K_HOLD, first + nf + i, 64'b101, {name, " bwd"});
        expect_at(K_HOLD, first + nf + nb, 64'b110, {name, " end"});
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] a_mem;
        int k;
        a_mem = caddr(2, 7, 3);

        rst_n = 1'b0; we = 1'b0; addr = '0; data_in = '0;
        step();
        addr = a_mem;
        expect_at(K_HOLD, cyc, 64'b110, "reset holds");
        expect_at(K_DATA, cyc, 64'd0, "reset data_out");
        expect_at(K_CADDR, cyc, 64'd0, "reset core_addr");
        step();
        rst_n = 1'b1;
        idle(2);

        // single forward pass
        k = cyc;
        hold_profile(k + 1, 6, 0, "fwd pass");
        wr(caddr(7, 0, 0), 64'd1);
        idle(7);
        rd(caddr(7, 0, 3), 64'd1, "pass count after fwd");
        rd(caddr(7, 0, 2), 64'd0, "status idle");

        // chained pass
        wr(caddr(7, 0, 4), 64'd1);
        rd(caddr(7, 0, 4), 64'd1, "mode readback");
        k = cyc;
        hold_profile(k + 1, 6, 6, "chain pass");
        wr(caddr(7, 0, 0), 64'd1);
        idle(13);
        rd(caddr(7, 0, 3), 64'd2, "pass count after chain");
        wr(caddr(7, 0, 4), 64'd0);
        rd(caddr(7, 0, 6), 64'd0, "unmapped ctrl idx");
        rd(caddr(7, 1, 2), 64'd0, "ctrl region idx_hi nonzero");

        // host write forwarding, idle then during pass
        wq.push_back('{a: a_mem, d: 64'd15});
        wr(a_mem, 64'd15);
        rd(a_mem, {40'h0, a_mem} ^ CORE_KEY, "core read");
        rd(caddr(3, 1, 1), {40'h0, caddr(3, 1, 1)} ^ CORE_KEY, "core read 2");
        k = cyc;
        hold_profile(k + 1, 6, 0, "pass w/ blocked write");
        wr(caddr(7, 0, 0), 64'd1);
        idle(1);
        wr(a_mem, 64'd15);
        rd(caddr(7, 0, 2), 64'h13, "status during fwd");
        idle(4);
        rd(caddr(7, 0, 2), 64'h10, "status write error");
        wr(caddr(7, 0, 5), 64'd1);
        rd(caddr(7, 0, 2), 64'd0, "status after clear");

        // start forward during backprop
        k = cyc;
        hold_profile(k + 1, 0, 6, "bwd pass");
        wr(caddr(7, 0, 1), 64'd1);
        idle(1);
        wr(caddr(7, 0, 0), 64'd1);
        idle(6);
        rd(caddr(7, 0, 2), 64'h08, "status start error");
        wr(caddr(7, 0, 5), 64'd1);
        rd(caddr(7, 0, 2), 64'd0, "status cleared");
        rd(caddr(7, 0, 3), 64'd4, "pass count before reset");

        // reset in the third forward cycle
        k = cyc;
        expect_at(K_HOLD, k + 1, 64'b011, "abort fwd 1");
        expect_at(K_HOLD, k + 2, 64'b011, "abort fwd 2");
        expect_at(K_HOLD, k + 3, 64'b110, "abort reset holds");
        expect_at(K_DATA, k + 3, 64'd0, "abort data_out");
        expect_at(K_CADDR, k + 3, 64'd0, "abort core_addr");
        wr(caddr(7, 0, 0), 64'd1);
        step();
        addr = a_mem;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rd(caddr(7, 0, 3), 64'd0, "pass count after abort");
        expect_at(K_HOLD, cyc, 64'b110, "idle after abort");
        idle(1);

        // pass counter wrap
        force dut.pass_count = '1;
        step();
        release dut.pass_count;
        rd(caddr(7, 0, 3), '1, "pass count preload");
        k = cyc;
        hold_profile(k + 1, 0, 6, "wrap pass");
        wr(caddr(7, 0, 1), 64'd1);
        idle(7);
        rd(caddr(7, 0, 3), 64'd0, "pass count wrap");

        idle(3);
        chk("pending expectations", 64'(eq.size()), 64'd0);
        chk("pending core writes", 64'(wq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
